// File: rtl/freq_peak_detect.sv
// Peak-bin finder for a 16-point FFT frame.
// Squares each bin, sums re^2+im^2 and reports the strongest index.
module freq_peak_detect #(
  parameter int DW    = 16,
  parameter int NBINS = 16,
  parameter int IDXW  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fft_valid,
  input  logic [2*DW-1:0] fft_d0,
  input  logic [2*DW-1:0] fft_d1,
  input  logic [2*DW-1:0] fft_d2,
  input  logic [2*DW-1:0] fft_d3,
  input  logic [2*DW-1:0] fft_d4,
  input  logic [2*DW-1:0] fft_d5,
  input  logic [2*DW-1:0] fft_d6,
  input  logic [2*DW-1:0] fft_d7,
  input  logic [2*DW-1:0] fft_d8,
  input  logic [2*DW-1:0] fft_d9,
  input  logic [2*DW-1:0] fft_d10,
  input  logic [2*DW-1:0] fft_d11,
  input  logic [2*DW-1:0] fft_d12,
  input  logic [2*DW-1:0] fft_d13,
  input  logic [2*DW-1:0] fft_d14,
  input  logic [2*DW-1:0] fft_d15,
  output logic            done,
  output logic [IDXW-1:0] freq,
  output logic [2*DW-1:0] peak_mag,
  output logic            busy,
  output logic            overrun
);

  localparam logic [IDXW-1:0] LAST = IDXW'(NBINS - 1);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t state, state_n;
  logic [IDXW-1:0] k, k_n;
  logic capture, drop;
  logic [2*DW-1:0] frame [NBINS];
  logic [2*DW-1:0] bank [NBINS];

  always_comb begin
    frame[0]  = fft_d0;
    frame[1]  = fft_d1;
    frame[2]  = fft_d2;
    frame[3]  = fft_d3;
    frame[4]  = fft_d4;
    frame[5]  = fft_d5;
    frame[6]  = fft_d6;
    frame[7]  = fft_d7;
    frame[8]  = fft_d8;
    frame[9]  = fft_d9;
    frame[10] = fft_d10;
    frame[11] = fft_d11;
    frame[12] = fft_d12;
    frame[13] = fft_d13;
    frame[14] = fft_d14;
    frame[15] = fft_d15;
  end

  always_comb begin
    state_n = state;
    k_n     = k;
    capture = 1'b0;
    drop    = 1'b0;
    unique case (state)
      IDLE: begin
        if (fft_valid) begin
          capture = 1'b1;
          state_n = ISSUE;
          k_n     = '0;
        end
      end
      ISSUE: begin
        k_n = k + 1'b1;
        if (k == LAST) begin
          // a strobe on the final issue edge chains the next frame
          if (fft_valid) begin
            capture = 1'b1;
            k_n     = '0;
          end else begin
            state_n = IDLE;
          end
        end else if (fft_valid) begin
          drop = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state == ISSUE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      k       <= '0;
      overrun <= 1'b0;
      for (int i = 0; i < NBINS; i++) bank[i] <= '0;
    end else begin
      state <= state_n;
      k     <= k_n;
      if (drop) overrun <= 1'b1;
      if (capture)
        for (int i = 0; i < NBINS; i++) bank[i] <= frame[i];
    end
  end

  logic signed [DW-1:0]   re, im;
  logic signed [2*DW-1:0] re_sq, im_sq;

  assign re    = bank[k][2*DW-1:DW];
  assign im    = bank[k][DW-1:0];
  assign re_sq = re * re;
  assign im_sq = im * im;

  logic            s1_v, s1_last, s2_v, s2_last;
  logic [IDXW-1:0] s1_idx, s2_idx, best_idx;
  logic [2*DW-1:0] s1_sqre, s1_sqim, s2_pwr, best_pwr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v    <= 1'b0;
      s1_last <= 1'b0;
      s1_idx  <= '0;
      s1_sqre <= '0;
      s1_sqim <= '0;
      s2_v    <= 1'b0;
      s2_last <= 1'b0;
      s2_idx  <= '0;
      s2_pwr  <= '0;
    end else begin
      s1_v    <= busy;
      s1_last <= busy && (k == LAST);
      s1_idx  <= k;
      s1_sqre <= unsigned'(re_sq);
      s1_sqim <= unsigned'(im_sq);
      s2_v    <= s1_v;
      s2_last <= s1_last;
      s2_idx  <= s1_idx;
      s2_pwr  <= s1_sqre + s1_sqim;
    end
  end

  // strict > keeps the lowest index on ties
  logic            take;
  logic [IDXW-1:0] cand_idx;
  logic [2*DW-1:0] cand_pwr;

  always_comb begin
    take     = (s2_idx == '0) || (s2_pwr > best_pwr);
    cand_idx = take ? s2_idx : best_idx;
    cand_pwr = take ? s2_pwr : best_pwr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      best_idx <= '0;
      best_pwr <= '0;
      done     <= 1'b0;
      freq     <= '0;
      peak_mag <= '0;
    end else begin
      done <= s2_v && s2_last;
      if (s2_v) begin
        best_idx <= cand_idx;
        best_pwr <= cand_pwr;
      end
      if (s2_v && s2_last) begin
        freq     <= cand_idx;
        peak_mag <= cand_pwr;
      end
    end
  end

endmodule

// File: tb/tb_freq_peak_detect.sv
// Scoreboard bench for freq_peak_detect.
// Directed frames; a monitor checks each done against queued results.
module tb_freq_peak_detect;

  logic        clk = 1'b0;
  logic        rst;
  logic        fft_valid;
  logic [31:0] d [16];
  logic        done, busy, overrun;
  logic [3:0]  freq;
  logic [31:0] peak_mag;

  int cyc    = 0;
  int checks = 0;
  int passes = 0;

  typedef struct {
    int          f;
    logic [31:0] p;
    int          c;
  } exp_t;

  exp_t sbq [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  freq_peak_detect dut (
    .clk(clk), .rst(rst), .fft_valid(fft_valid),
    .fft_d0(d[0]), .fft_d1(d[1]), .fft_d2(d[2]), .fft_d3(d[3]),
    .fft_d4(d[4]), .fft_d5(d[5]), .fft_d6(d[6]), .fft_d7(d[7]),
    .fft_d8(d[8]), .fft_d9(d[9]), .fft_d10(d[10]), .fft_d11(d[11]),
    .fft_d12(d[12]), .fft_d13(d[13]), .fft_d14(d[14]), .fft_d15(d[15]),
    .done(done), .freq(freq), .peak_mag(peak_mag),
    .busy(busy), .overrun(overrun)
  );

  task automatic chk(input string name, input longint act,
                     input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
                  name, act, exp, cyc);
  endtask

  always @(negedge clk) begin
    if (!rst && done) begin
      if (sbq.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("freq", freq, e.f);
        chk("peak_mag", peak_mag, e.p);
        chk("done_cycle", cyc, e.c);
      end
    end
  end

  task automatic set_frame(input logic [31:0] bg, input int pi,
                           input logic [31:0] pk);
    for (int i = 0; i < 16; i++) d[i] = bg;
    d[pi] = pk;
  endtask

  // call at a negedge; returns one negedge later
  task automatic strobe(input bit exp, input int ef,
                        input logic [31:0] ep);
    fft_valid = 1'b1;
    if (exp) sbq.push_back('{ef, ep, cyc + 19});
    @(negedge clk);
    fft_valid = 1'b0;
    for (int i = 0; i < 16; i++) d[i] = $urandom;
  endtask

  task automatic drain();
    repeat (24) @(negedge clk);
    chk("queue_empty", sbq.size(), 0);
  endtask

  initial begin
    rst = 1'b1;
    fft_valid = 1'b0;
    for (int i = 0; i < 16; i++) d[i] = '0;
    repeat (2) @(negedge clk);
    chk("rst_done", done, 0);
    chk("rst_freq", freq, 0);
    chk("rst_peak", peak_mag, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    rst = 1'b0;
    @(negedge clk);

    // single tone
    set_frame(32'h0, 5, {16'd1000, 16'd0});
    strobe(1, 5, 32'd1_000_000);
    chk("busy_after_capture", busy, 1);
    drain();
    chk("busy_idle", busy, 0);

    // tie keeps lowest index
    set_frame({16'd10, 16'd10}, 3, {16'd300, 16'd400});
    d[11] = {16'd300, 16'd400};
    strobe(1, 3, 32'd250_000);
    drain();

    // extremes
    set_frame({16'h7FFF, 16'h0}, 9, {16'h8000, 16'h8000});
    strobe(1, 9, 32'h8000_0000);
    drain();

    // all-zero frame
    set_frame(32'h0, 0, 32'h0);
    strobe(1, 0, 32'h0);
    drain();

    // back-to-back streaming
    set_frame({16'd3, -16'sd4}, 1, {16'd500, 16'd0});
    strobe(1, 1, 32'd250_000);
    repeat (15) @(negedge clk);
    set_frame({16'd3, -16'sd4}, 15, {16'd400, 16'd0});
    strobe(1, 15, 32'd160_000);
    repeat (15) @(negedge clk);
    set_frame({16'd3, -16'sd4}, 0, {16'd200, 16'd0});
    strobe(1, 0, 32'd40_000);
    repeat (15) @(negedge clk);
    set_frame({16'd3, -16'sd4}, 7, {16'd300, 16'd0});
    strobe(1, 7, 32'd90_000);
    drain();
    chk("no_overrun_stream", overrun, 0);

    // overrun
    set_frame(32'h0, 2, {16'd700, 16'd0});
    strobe(1, 2, 32'd490_000);
    repeat (7) @(negedge clk);
    set_frame(32'h0, 6, {16'd900, 16'd0});
    strobe(0, 0, 32'h0);
    @(negedge clk);
    chk("overrun_set", overrun, 1);
    drain();
    chk("overrun_sticky", overrun, 1);

    // reset mid-frame
    set_frame(32'h0, 4, {16'd50, 16'd0});
    strobe(0, 0, 32'h0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_done", done, 0);
    chk("mid_rst_freq", freq, 0);
    chk("mid_rst_peak", peak_mag, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_overrun", overrun, 0);
    @(negedge clk);
    rst = 1'b0;
    drain();
    set_frame({16'd1, 16'd1}, 12, {-16'sd20, 16'd30});
    strobe(1, 12, 32'd1_300);
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
